// File: rtl/fir_17_pkg.sv
// Shared constants and types for the 17-tap symmetric low-pass FIR.
// Coefficients are Q1.15 and sum to 32768, so the DC gain is exactly unity.
package fir_17_pkg;

  localparam int unsigned NTAPS  = 17;
  localparam int unsigned NPAIRS = NTAPS / 2;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned ACC_W  = 38;
  localparam int          RND    = 2 ** 14;
  localparam int unsigned SHIFT  = 15;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam coef_t COEFS [NTAPS] = '{
    -16'sd64,  -16'sd128,  16'sd0,    16'sd576,  16'sd1536, 16'sd2816,
     16'sd4032, 16'sd4864, 16'sd5504, 16'sd4864, 16'sd4032, 16'sd2816,
     16'sd1536, 16'sd576,  16'sd0,   -16'sd128, -16'sd64
  };

  // Round half-up, then drop the Q1.15 fraction bits.
  function automatic acc_t round_shift(input acc_t acc);
    acc_t biased;
    biased = acc + acc_t'(RND);
    return biased >>> SHIFT;
  endfunction

endpackage

// File: rtl/fir_17_delay_line.sv
// Enabled shift register holding the filter history; taps[0] is the newest sample.
// Cleared asynchronously whenever rst is low.
module fir_17_delay_line
  import fir_17_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = NTAPS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              din,
  output logic [DEPTH-1:0][WIDTH-1:0]   taps
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps <= '0;
    end else if (en) begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/fir_17.sv
// 17-tap symmetric FIR: pre-add mirrored taps, 9 products, round half-up, saturate.
// One sample per enabled clock; data_o is registered with one clock of latency.
module fir_17
  import fir_17_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic signed [WIDTH-1:0] data_i,
  output logic signed [WIDTH-1:0] data_o
);

  localparam acc_t SAT_MAX = acc_t'(2 ** (WIDTH - 1) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (WIDTH - 1)));

  typedef logic signed [WIDTH:0] pre_t;

  logic [NTAPS-1:0][WIDTH-1:0] taps;
  pre_t                        pre [NPAIRS+1];
  acc_t                        acc;
  acc_t                        rounded;
  logic signed [WIDTH-1:0]     sat_val;

  fir_17_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (NTAPS)
  ) u_delay_line (
    .clk  (clk),
    .rst  (rst),
    .en   (start_i),
    .din  (data_i),
    .taps (taps)
  );

  // Mirrored taps share a coefficient; the extra bit keeps the pair sum exact.
  always_comb begin
    for (int unsigned j = 0; j < NPAIRS; j++) begin
      pre[j] = $signed({taps[j][WIDTH-1], taps[j]})
             + $signed({taps[NTAPS-1-j][WIDTH-1], taps[NTAPS-1-j]});
    end
    pre[NPAIRS] = $signed({taps[NPAIRS][WIDTH-1], taps[NPAIRS]});
  end

  always_comb begin
    acc = '0;
    for (int unsigned j = 0; j <= NPAIRS; j++) begin
      acc = acc + acc_t'(pre[j]) * acc_t'(COEFS[j]);
    end
  end

  always_comb begin
    rounded = round_shift(acc);
    if (rounded > SAT_MAX) begin
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (rounded < SAT_MIN) begin
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat_val = rounded[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o <= '0;
    end else if (start_i) begin
      data_o <= sat_val;
    end
  end

endmodule

// File: tb/tb_fir_17.sv
// Directed and random stimulus for fir_17 against a direct-form 17-term reference model.
// Expected outputs are queued as each input is driven and popped after the clock edge.
module tb_fir_17;

  logic               clk;
  logic               rst;
  logic               start_i;
  logic signed [15:0] data_i;
  logic signed [15:0] data_o;

  int n_cmp = 0;
  int n_err = 0;

  int coef [17] = '{-64, -128, 0, 576, 1536, 2816, 4032, 4864, 5504,
                    4864, 4032, 2816, 1536, 576, 0, -128, -64};
  int imp_ref [18] = '{-32, -64, 0, 288, 768, 1408, 2016, 2432, 2752,
                       2432, 2016, 1408, 768, 288, 0, -64, -32, 0};
  int hist [17];
  int last_out;
  int sb [$];

  fir_17 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .data_i  (data_i),
    .data_o  (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_out();
    longint acc;
    acc = 0;
    for (int i = 0; i < 17; i++) acc += longint'(coef[i]) * longint'(hist[i]);
    acc = (acc + 16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 17; i++) hist[i] = 0;
    last_out = 0;
    sb.delete();
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one clock of stimulus; use_ref forces a hand-derived expected value.
  task automatic step(input string tag, input int d, input bit st,
                      input bit use_ref, input int ref_val);
    int exp;
    start_i = st;
    data_i  = 16'(d);
    if (st) begin
      exp = model_out();
      for (int i = 16; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = d;
      last_out = exp;
    end else begin
      exp = last_out;
    end
    sb.push_back(use_ref ? ref_val : exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s scoreboard empty observed=%0d", tag, int'(data_o));
    end else begin
      check(tag, int'(data_o), sb.pop_front());
    end
  endtask

  initial begin
    int pat [17];

    // Reset held with random input and the filter enabled.
    rst = 1'b0;
    start_i = 1'b1;
    data_i = '0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      data_i = 16'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
      check("reset_hold", int'(data_o), 0);
    end
    #2 rst = 1'b1;
    for (int k = 0; k < 18; k++) step("reset_zero", 0, 1'b1, 1'b0, 0);

    // Impulse: the response is h/2 delayed by one edge.
    step("impulse_in", 16384, 1'b1, 1'b1, 0);
    for (int k = 0; k < 18; k++) step("impulse", 0, 1'b1, 1'b1, imp_ref[k]);

    // DC step with a 5-clock stall partway through the fill.
    for (int k = 0; k < 8; k++) step("dc_fill", 10000, 1'b1, 1'b0, 0);
    for (int k = 0; k < 5; k++) step("dc_stall", 12345, 1'b0, 1'b0, 0);
    for (int k = 0; k < 10; k++) step("dc_fill", 10000, 1'b1, 1'b0, 0);
    check("dc_pos_settled", int'(data_o), 10000);
    for (int k = 0; k < 18; k++) step("dc_neg", -32768, 1'b1, 1'b0, 0);
    check("dc_neg_settled", int'(data_o), -32768);

    // Sign-matched windows drive the accumulator past both rails.
    for (int i = 0; i < 17; i++) pat[i] = (coef[i] < 0) ? -32768 : 32767;
    for (int i = 0; i < 17; i++) step("sat_pos", pat[i], 1'b1, 1'b0, 0);
    step("sat_pos_out", 0, 1'b1, 1'b0, 0);
    check("sat_pos_clamp", int'(data_o), 32767);
    for (int i = 0; i < 17; i++) pat[i] = (coef[i] < 0) ? 32767 : -32768;
    for (int i = 0; i < 17; i++) step("sat_neg", pat[i], 1'b1, 1'b0, 0);
    step("sat_neg_out", 0, 1'b1, 1'b0, 0);
    check("sat_neg_clamp", int'(data_o), -32768);

    // Reset asserted between edges in the middle of an impulse response.
    for (int k = 0; k < 17; k++) step("flush", 0, 1'b1, 1'b0, 0);
    step("mid_imp_in", 16384, 1'b1, 1'b0, 0);
    for (int k = 0; k < 6; k++) step("mid_imp", 0, 1'b1, 1'b1, imp_ref[k]);
    #3 rst = 1'b0;
    #1 check("mid_reset_async", int'(data_o), 0);
    model_reset();
    @(posedge clk);
    #1 check("mid_reset_hold", int'(data_o), 0);
    #2 rst = 1'b1;
    for (int k = 0; k < 18; k++) step("mid_reset_zero", 0, 1'b1, 1'b0, 0);

    // Random stream with random stalls against the reference model.
    for (int k = 0; k < 300; k++) begin
      step("random", int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 9) < 8), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
